// File: rtl/pc_unit_pkg.sv
// Shared types and encodings for the miniCPU program-counter unit.
// Holds the data-bus type, condition/state encodings and the condition evaluator.
package pc_unit_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CC_W    = 2;
  localparam int unsigned COND_W  = 3;
  localparam int unsigned BRCNT_W = 8;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CC_W-1:0]   cc_t;

  localparam logic [COND_W-1:0] COND_ALWAYS = 3'd0;
  localparam logic [COND_W-1:0] COND_EQ     = 3'd1;
  localparam logic [COND_W-1:0] COND_NE     = 3'd2;
  localparam logic [COND_W-1:0] COND_GT     = 3'd3;
  localparam logic [COND_W-1:0] COND_LT     = 3'd4;
  localparam logic [COND_W-1:0] COND_GE     = 3'd5;
  localparam logic [COND_W-1:0] COND_LE     = 3'd6;
  localparam logic [COND_W-1:0] COND_NEVER  = 3'd7;

  typedef enum logic [1:0] {
    PCU_IDLE = 2'd0,
    PCU_RUN  = 2'd1,
    PCU_HALT = 2'd2
  } pcu_state_e;

  typedef struct packed {
    logic [COND_W-1:0] cond;
    data_t             target;
  } jump_req_t;

  // cc encoding: 1x equal, 01 greater, 00 less; nothing but ALWAYS holds without a valid compare.
  function automatic logic cond_holds(logic [COND_W-1:0] cond, cc_t cc, logic cc_valid);
    logic r;
    r = 1'b0;
    case (cond)
      COND_ALWAYS: r = 1'b1;
      COND_EQ:     r = cc_valid & cc[1];
      COND_NE:     r = cc_valid & ~cc[1];
      COND_GT:     r = cc_valid & (cc == 2'b01);
      COND_LT:     r = cc_valid & (cc == 2'b00);
      COND_GE:     r = cc_valid & (cc[1] | cc[0]);
      COND_LE:     r = cc_valid & (cc[1] | ~cc[0]);
      COND_NEVER:  r = 1'b0;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_unit_cond_eval.sv
// Combinational jump-condition evaluator against a latched compare code.
module pc_unit_cond_eval
  import pc_unit_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  cc_t               cc,
  input  logic              cc_valid,
  output logic              take
);

  assign take = cond_holds(cond, cc, cc_valid);

endmodule

// File: rtl/pc_unit.sv
// Program counter, condition-code latch and run/halt FSM for the miniCPU.
// Optional taken-branch counter enabled by defining PCU_BRCNT_EN.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter data_t RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              advance,
  input  logic              jmp,
  input  logic [COND_W-1:0] cond,
  input  data_t             target,
  input  cc_t               alu_cc,
  input  logic              cc_we,
  output data_t             pc,
  output logic              taken,
  output cc_t               cc,
  output logic              cc_valid,
  output logic              running
`ifdef PCU_BRCNT_EN
  ,
  output logic [BRCNT_W-1:0] branch_cnt
`endif
);

  pcu_state_e state_q, state_d;
  data_t      pc_d;
  data_t      pc_inc;
  cc_t        cc_d;
  logic       cc_valid_d;
  logic       taken_d;
  logic       take;
  jump_req_t  jreq;

  assign jreq   = '{cond: cond, target: target};
  assign pc_inc = pc + data_t'(1);

  // Evaluates against the registered cc only: no bypass from a same-cycle capture.
  pc_unit_cond_eval u_cond_eval (
    .cond     (jreq.cond),
    .cc       (cc),
    .cc_valid (cc_valid),
    .take     (take)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    cc_d       = cc;
    cc_valid_d = cc_valid;
    taken_d    = 1'b0;
    case (state_q)
      PCU_IDLE: begin
        if (start) begin
          state_d    = PCU_RUN;
          pc_d       = RESET_PC;
          cc_valid_d = 1'b0;
        end
      end
      PCU_RUN: begin
        if (cc_we) begin
          cc_d       = alu_cc;
          cc_valid_d = 1'b1;
        end
        if (halt) begin
          state_d = PCU_HALT;
        end else if (start) begin
          pc_d       = RESET_PC;
          cc_d       = cc;
          cc_valid_d = 1'b0;
        end else if (jmp) begin
          if (take) begin
            pc_d    = jreq.target;
            taken_d = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end else if (advance) begin
          pc_d = pc_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PCU_IDLE;
      pc       <= RESET_PC;
      cc       <= '0;
      cc_valid <= 1'b0;
      taken    <= 1'b0;
      running  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      cc       <= cc_d;
      cc_valid <= cc_valid_d;
      taken    <= taken_d;
      running  <= (state_d == PCU_RUN);
    end
  end

`ifdef PCU_BRCNT_EN
  logic [BRCNT_W-1:0] cnt_d;
  logic               clr_c;

  // Saturating count of taken jumps; cleared whenever start is honoured.
  always_comb begin
    clr_c = start && ((state_q == PCU_IDLE) || ((state_q == PCU_RUN) && !halt));
    cnt_d = branch_cnt;
    if (clr_c) begin
      cnt_d = '0;
    end else if (taken_d && (branch_cnt != '1)) begin
      cnt_d = branch_cnt + BRCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= '0;
    end else begin
      branch_cnt <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit; expected {pc,taken,cc_valid,running} go through a queue.
module tb_pc_unit;
  import pc_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, halt = 1'b0, advance = 1'b0, jmp = 1'b0, cc_we = 1'b0;
  logic [2:0] cond = 3'd0;
  logic [7:0] target = 8'h00;
  logic [1:0] alu_cc = 2'b00;
  logic [7:0] pc;
  logic       taken;
  logic [1:0] cc;
  logic       cc_valid, running;
`ifdef PCU_BRCNT_EN
  logic [7:0] branch_cnt;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ep = 8'h00;
  logic [10:0] sbq[$];

  // Truth tables per cc value, bit k = outcome of cond k.
  logic [7:0] tk_tab [3] = '{8'b00101101, 8'b01100011, 8'b01010101};
  logic [1:0] cc_tab [3] = '{2'b01, 2'b10, 2'b00};

  pc_unit #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .advance(advance),
    .jmp(jmp), .cond(cond), .target(target), .alu_cc(alu_cc), .cc_we(cc_we),
    .pc(pc), .taken(taken), .cc(cc), .cc_valid(cc_valid), .running(running)
`ifdef PCU_BRCNT_EN
    , .branch_cnt(branch_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs();
    return {pc, taken, cc_valid, running};
  endfunction

  task automatic drive(input logic s, input logic h, input logic a, input logic j,
                       input logic [2:0] c, input logic [7:0] t,
                       input logic [1:0] acc, input logic we);
    start = s; halt = h; advance = a; jmp = j; cond = c; target = t; alu_cc = acc; cc_we = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] g;
    logic [10:0] e, o;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 3'd0, 8'h00, 2'b00, 0);
    repeat (2) tick();
    g = {pc, taken, cc, cc_valid, running};
    checks++;
    if (g !== 13'h0) begin
      errors++;
      $display("FAIL reset: got pc=%h tk=%b cc=%b cv=%b run=%b want all zero", g[12:5], g[4], g[3:2], g[1], g[0]);
    end
`ifdef PCU_BRCNT_EN
    checks++;
    if (branch_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_brcnt: got %h want 00", branch_cnt);
    end
`endif
    rst_n = 1'b1;
    tick();
    drive(0, 0, 1, 1, COND_ALWAYS, 8'h77, 2'b00, 1);
    sbq.push_back({8'h00, 3'b000});
    tick();
    e = sbq.pop_front(); o = obs();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL idle_frozen: got pc=%h tcr=%b want pc=%h tcr=%b", o[10:3], o[2:0], e[10:3], e[2:0]);
    end
  endtask

  task automatic test_advance();
    logic [10:0] e, o;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1, 0, 0, 0, 3'd0, 8'h00, 2'b00, 0);
      else if (i < 4) drive(0, 0, 1, 0, 3'd0, 8'h00, 2'b00, 0);
      else drive(0, 0, 0, 0, 3'd0, 8'h00, 2'b00, 0);
      sbq.push_back({(i < 4) ? 8'(i) : 8'h03, 3'b001});
      tick();
      e = sbq.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL advance[%0d]: got pc=%h tcr=%b want pc=%h tcr=%b", i, o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
    ep = 8'h03;
  endtask

  task automatic test_invalid_cc();
    logic [10:0] e, o;
    logic [2:0]  cs [4] = '{COND_EQ, COND_ALWAYS, COND_NEVER, COND_LE};
    logic [3:0]  js = 4'b1111;
    logic [7:0]  ex [4] = '{8'h04, 8'h10, 8'h11, 8'h12};
    logic        tk [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, js[i], cs[i], (i == 1) ? 8'h10 : 8'h55, 2'b00, 0);
      sbq.push_back({ex[i], tk[i], 2'b01});
      tick();
      e = sbq.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL invalid_cc[%0d]: got pc=%h tcr=%b want pc=%h tcr=%b", i, o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
    ep = 8'h12;
  endtask

  task automatic test_wrap();
    logic [10:0] e, o;
    logic [7:0]  ex [3] = '{8'hFE, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(0, 0, 0, 1, COND_ALWAYS, 8'hFE, 2'b00, 0);
      else drive(0, 0, 1, 0, 3'd0, 8'h00, 2'b00, 0);
      sbq.push_back({ex[i], (i == 0), 2'b01});
      tick();
      e = sbq.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap[%0d]: got pc=%h tcr=%b want pc=%h tcr=%b", i, o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
    ep = 8'h00;
  endtask

  task automatic test_cond_table();
    logic [10:0] e, o;
    logic [7:0]  tgt;
    logic        tk;
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 3'd0, 8'h00, cc_tab[c], 1);
      sbq.push_back({ep, 3'b011});
      tick();
      e = sbq.pop_front(); o = obs();
      checks++;
      if (o !== e || cc !== cc_tab[c]) begin
        errors++;
        $display("FAIL cc_capture[%0d]: got pc=%h tcr=%b cc=%b want pc=%h tcr=%b cc=%b",
                 c, o[10:3], o[2:0], cc, e[10:3], e[2:0], cc_tab[c]);
      end
      for (int k = 0; k < 8; k++) begin
        tgt = 8'h40 + 8'(k * 16);
        tk  = tk_tab[c][k];
        ep  = tk ? tgt : ep + 8'd1;
        drive(0, 0, 0, 1, 3'(k), tgt, 2'b00, 0);
        sbq.push_back({ep, tk, 2'b11});
        tick();
        e = sbq.pop_front(); o = obs();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL cond[cc=%b,k=%0d]: got pc=%h tcr=%b want pc=%h tcr=%b",
                   cc_tab[c], k, o[10:3], o[2:0], e[10:3], e[2:0]);
        end
      end
    end
  endtask

  task automatic test_no_bypass();
    logic [10:0] e, o;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, COND_EQ, 8'hC0, 2'b10, (i == 0));
      ep = (i == 0) ? ep + 8'd1 : 8'hC0;
      sbq.push_back({ep, (i == 1), 2'b11});
      tick();
      e = sbq.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL no_bypass[%0d]: got pc=%h tcr=%b want pc=%h tcr=%b", i, o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
  endtask

  task automatic test_halt_and_async_reset();
    logic [10:0] e, o;
    logic [12:0] g;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(0, 1, 0, 1, COND_ALWAYS, 8'h33, 2'b00, 0);
        1: drive(1, 0, 0, 0, 3'd0, 8'h00, 2'b00, 0);
        2: drive(0, 0, 1, 0, 3'd0, 8'h00, 2'b00, 0);
        default: drive(0, 0, 0, 1, COND_ALWAYS, 8'h44, 2'b01, 1);
      endcase
      sbq.push_back({ep, 3'b010});
      tick();
      e = sbq.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL halt[%0d]: got pc=%h tcr=%b want pc=%h tcr=%b", i, o[10:3], o[2:0], e[10:3], e[2:0]);
      end
    end
    checks++;
    if (cc !== 2'b10) begin
      errors++;
      $display("FAIL halt_cc: got %b want 10", cc);
    end
    drive(0, 0, 0, 0, 3'd0, 8'h00, 2'b00, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    g = {pc, taken, cc, cc_valid, running};
    checks++;
    if (g !== 13'h0 || clk !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got pc=%h tk=%b cc=%b cv=%b run=%b clk=%b want zeros mid-high-phase",
               g[12:5], g[4], g[3:2], g[1], g[0], clk);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef PCU_BRCNT_EN
  task automatic test_brcnt();
    logic [10:0] e, o;
    drive(1, 0, 0, 0, 3'd0, 8'h00, 2'b00, 0);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 0, 1, COND_ALWAYS, 8'(i), 2'b00, 0);
      sbq.push_back({8'(i), 3'b101});
      tick();
      e = sbq.pop_front(); o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL brcnt_jmp[%0d]: got pc=%h tcr=%b want pc=%h tcr=%b", i, o[10:3], o[2:0], e[10:3], e[2:0]);
      end
      if (i == 9) begin
        checks++;
        if (branch_cnt !== 8'd10) begin
          errors++;
          $display("FAIL brcnt_10: got %h want 0a", branch_cnt);
        end
      end
    end
    checks++;
    if (branch_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL brcnt_sat: got %h want ff", branch_cnt);
    end
    drive(1, 0, 0, 0, 3'd0, 8'h00, 2'b00, 0);
    tick();
    checks++;
    if (branch_cnt !== 8'h00 || pc !== 8'h00) begin
      errors++;
      $display("FAIL brcnt_clear: got cnt=%h pc=%h want 00/00", branch_cnt, pc);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_advance();
    test_invalid_cc();
    test_wrap();
    test_cond_table();
    test_no_bypass();
    test_halt_and_async_reset();
`ifdef PCU_BRCNT_EN
    test_brcnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
